// File: rtl/h14tx_pkg.sv
// Shared types and fixed HDMI 1.4 period lengths for the TX island scheduler.
package h14tx_pkg;

  typedef enum logic [2:0] {
    CTRL        = 3'd0,
    ISL_PRE     = 3'd1,
    ISL_GUARD_L = 3'd2,
    ISL_DATA    = 3'd3,
    ISL_GUARD_T = 3'd4,
    VID_PRE     = 3'd5,
    VID_GUARD   = 3'd6,
    VIDEO       = 3'd7
  } period_t;

  localparam int IslPreLen = 8;
  localparam int GuardLen  = 2;
  localparam int PktLen    = 32;
  localparam int VidPreLen = 8;

  function automatic logic is_island(period_t p);
    return p inside {ISL_PRE, ISL_GUARD_L, ISL_DATA, ISL_GUARD_T};
  endfunction

endpackage

// File: rtl/h14tx_rr_arb.sv
// Round-robin pick over NumReq level requests; pointer advances past the winner
// on adv, or is reloaded (abort retry) on load.
module h14tx_rr_arb #(
  parameter int NumReq = 4,
  localparam int PtrW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NumReq-1:0] req,
  input  logic              adv,
  input  logic              load,
  input  logic [PtrW-1:0]   load_ptr,
  output logic [NumReq-1:0] pick,
  output logic              any
);

  logic [PtrW-1:0] ptr, win;
  int j;

  // Scan from the farthest slot back to ptr so the nearest requester wins last.
  always_comb begin
    pick = '0;
    win  = '0;
    j    = 0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NumReq) j = j - NumReq;
      if (req[j]) begin
        pick    = '0;
        pick[j] = 1'b1;
        win     = PtrW'(j);
      end
    end
  end

  assign any = |req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ptr <= '0;
    else if (load) ptr <= load_ptr;
    else if (adv)  ptr <= (int'(win) == NumReq - 1) ? '0 : win + 1'b1;
  end

endmodule

// File: rtl/h14tx_island_sched.sv
// Per-pixel HDMI 1.4 period sequencer and data-island packet arbiter.
// Optional H14TX_ISLAND_STATS_EN adds saturating island/packet counters.
module h14tx_island_sched
  import h14tx_pkg::*;
#(
  parameter int NumReq     = 4,
  parameter int BitWidth   = 12,
  parameter int BitHeight  = 11,
  parameter int HActive    = 1920,
  parameter int HTotal     = 2200,
  parameter int VActive    = 1080,
  parameter int VTotal     = 1125,
  parameter int MinCtrl    = 12,
  parameter int MaxPackets = 18
) (
  input  logic                 pixel_clk,
  input  logic                 rst,
  input  logic [BitWidth-1:0]  x,
  input  logic [BitHeight-1:0] y,
  input  logic [NumReq-1:0]    req,
  output logic [NumReq-1:0]    gnt,
  output logic                 pkt_first,
  output logic [4:0]           pkt_idx,
  output logic [2:0]           period,
  output logic                 sched_err
`ifdef H14TX_ISLAND_STATS_EN
  ,
  output logic [15:0]          isl_count,
  output logic [15:0]          pkt_count
`endif
);

  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CcW  = $clog2(MinCtrl + 1);
  localparam int PcW  = $clog2(MaxPackets + 1);

  period_t           state, nxt_state, vid_p;
  logic [2:0]        phase, nxt_phase;
  logic [CcW-1:0]    ctrl_cnt, nxt_ctrl_cnt;
  logic [PcW-1:0]    pkt_cnt, nxt_pkt_cnt;
  logic [NumReq-1:0] nxt_gnt, pick;
  logic [4:0]        nxt_idx;
  logic              nxt_first, nxt_err, vid_hit, any_req;
  logic              active_row, next_active, open_ok, cont_ok;
  logic              arb_adv, arb_load;
  logic [PtrW-1:0]   gnt_ptr;
  int                xi, yn, vid_rsv;

  h14tx_rr_arb #(.NumReq(NumReq)) u_arb (
    .clk      (pixel_clk),
    .rst      (rst),
    .req      (req),
    .adv      (arb_adv),
    .load     (arb_load),
    .load_ptr (gnt_ptr),
    .pick     (pick),
    .any      (any_req)
  );

  // Raster classification and island budget checks for the incoming pixel.
  always_comb begin
    xi          = int'(x);
    yn          = (int'(y) == VTotal - 1) ? 0 : int'(y) + 1;
    active_row  = int'(y) < VActive;
    next_active = yn < VActive;
    vid_rsv     = next_active ? VidPreLen + GuardLen : 0;
    vid_hit     = 1'b1;
    vid_p       = VIDEO;
    if (active_row && xi < HActive)
      vid_p = VIDEO;
    else if (next_active && xi >= HTotal - VidPreLen - GuardLen && xi < HTotal - GuardLen)
      vid_p = VID_PRE;
    else if (next_active && xi >= HTotal - GuardLen)
      vid_p = VID_GUARD;
    else
      vid_hit = 1'b0;
    open_ok = int'(ctrl_cnt) >= MinCtrl && any_req &&
              xi + IslPreLen + 2 * GuardLen + PktLen + MinCtrl + vid_rsv <= HTotal;
    cont_ok = any_req && int'(pkt_cnt) < MaxPackets &&
              xi + PktLen + GuardLen + MinCtrl + vid_rsv <= HTotal;
  end

  always_comb begin
    gnt_ptr = '0;
    for (int i = 0; i < NumReq; i++)
      if (gnt[i]) gnt_ptr = PtrW'(i);
  end

  always_comb begin
    nxt_state   = CTRL;
    nxt_phase   = '0;
    nxt_gnt     = '0;
    nxt_first   = 1'b0;
    nxt_idx     = '0;
    nxt_pkt_cnt = pkt_cnt;
    nxt_err     = 1'b0;
    arb_adv     = 1'b0;
    arb_load    = 1'b0;
    if (vid_hit) begin
      nxt_state = vid_p;
      // Video overrides an island in flight; the aborted winner keeps its turn.
      if (is_island(state)) begin
        nxt_err  = (vid_p != VID_GUARD);
        arb_load = |gnt;
      end
    end else begin
      case (state)
        CTRL: if (open_ok) begin
          nxt_state   = ISL_PRE;
          nxt_pkt_cnt = '0;
        end
        ISL_PRE: if (phase == 3'(IslPreLen - 1)) nxt_state = ISL_GUARD_L;
                 else begin nxt_state = ISL_PRE; nxt_phase = phase + 3'd1; end
        ISL_GUARD_L: if (phase == 3'(GuardLen - 1)) begin
          if (any_req) begin
            nxt_state   = ISL_DATA;
            nxt_gnt     = pick;
            nxt_first   = 1'b1;
            arb_adv     = 1'b1;
            nxt_pkt_cnt = PcW'(1);
          end else begin
            nxt_state = ISL_GUARD_T;
          end
        end else begin
          nxt_state = ISL_GUARD_L;
          nxt_phase = phase + 3'd1;
        end
        ISL_DATA: begin
          nxt_state = ISL_DATA;
          if (pkt_idx == 5'(PktLen - 1)) begin
            if (cont_ok) begin
              nxt_gnt     = pick;
              nxt_first   = 1'b1;
              arb_adv     = 1'b1;
              nxt_pkt_cnt = pkt_cnt + PcW'(1);
            end else begin
              nxt_state = ISL_GUARD_T;
            end
          end else begin
            nxt_gnt = gnt;
            nxt_idx = pkt_idx + 5'd1;
          end
        end
        ISL_GUARD_T: if (phase != 3'(GuardLen - 1)) begin
          nxt_state = ISL_GUARD_T;
          nxt_phase = phase + 3'd1;
        end
        default: ;
      endcase
    end
    if (nxt_state != CTRL)                nxt_ctrl_cnt = '0;
    else if (int'(ctrl_cnt) >= MinCtrl)   nxt_ctrl_cnt = ctrl_cnt;
    else                                  nxt_ctrl_cnt = ctrl_cnt + CcW'(1);
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state     <= CTRL;
      phase     <= '0;
      gnt       <= '0;
      pkt_first <= 1'b0;
      pkt_idx   <= '0;
      sched_err <= 1'b0;
      ctrl_cnt  <= '0;
      pkt_cnt   <= '0;
    end else begin
      state     <= nxt_state;
      phase     <= nxt_phase;
      gnt       <= nxt_gnt;
      pkt_first <= nxt_first;
      pkt_idx   <= nxt_idx;
      sched_err <= nxt_err;
      ctrl_cnt  <= nxt_ctrl_cnt;
      pkt_cnt   <= nxt_pkt_cnt;
    end
  end

  assign period = state;

`ifdef H14TX_ISLAND_STATS_EN
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      isl_count <= '0;
      pkt_count <= '0;
    end else begin
      if (state == CTRL && nxt_state == ISL_PRE && isl_count != 16'hFFFF)
        isl_count <= isl_count + 16'd1;
      if (arb_adv && pkt_count != 16'hFFFF)
        pkt_count <= pkt_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_h14tx_island_sched.sv
// Directed bench for h14tx_island_sched at 1080p timing with four requesters.
module tb_h14tx_island_sched;

  logic        pixel_clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] x = '0;
  logic [10:0] y = '0;
  logic [3:0]  req = '0;
  logic [3:0]  gnt;
  logic        pkt_first;
  logic [4:0]  pkt_idx;
  logic [2:0]  period;
  logic        sched_err;
`ifdef H14TX_ISLAND_STATS_EN
  logic [15:0] isl_count, pkt_count;
`endif

  h14tx_island_sched dut (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .x         (x),
    .y         (y),
    .req       (req),
    .gnt       (gnt),
    .pkt_first (pkt_first),
    .pkt_idx   (pkt_idx),
    .period    (period),
    .sched_err (sched_err)
`ifdef H14TX_ISLAND_STATS_EN
    ,
    .isl_count (isl_count),
    .pkt_count (pkt_count)
`endif
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    int         vx;
    int         vy;
    logic [3:0] vreq;
    logic [2:0] vper;
    logic [3:0] vgnt;
  } vec_t;

  vec_t       vecs[19];
  int         checks = 0;
  int         failures = 0;
  logic [2:0] rp[2200];
  logic [3:0] rg[2200];
  logic       rf[2200];
  logic [4:0] ri[2200];
  logic       re[2200];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run(input int yy, input int x0, input int x1);
    for (int xx = x0; xx <= x1; xx++) begin
      x = 12'(xx);
      y = 11'(yy);
      @(posedge pixel_clk);
      #1;
      rp[xx] = period; rg[xx] = gnt; rf[xx] = pkt_first;
      ri[xx] = pkt_idx; re[xx] = sched_err;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_gnt"}, int'(gnt), 0);
    chk({tag, "_first"}, int'(pkt_first), 0);
    chk({tag, "_idx"}, int'(pkt_idx), 0);
    chk({tag, "_err"}, int'(sched_err), 0);
  endtask

  function automatic int count_first(input int x0, input int x1);
    int n = 0;
    for (int k = x0; k <= x1; k++) if (rf[k]) n++;
    return n;
  endfunction

  initial begin
    // Raster classification with no requests: period is a pure function of x/y.
    vecs[0]  = '{0,    0,    4'h0, 3'd7, 4'h0};
    vecs[1]  = '{1919, 0,    4'h0, 3'd7, 4'h0};
    vecs[2]  = '{1920, 0,    4'h0, 3'd0, 4'h0};
    vecs[3]  = '{2189, 0,    4'h0, 3'd0, 4'h0};
    vecs[4]  = '{2190, 0,    4'h0, 3'd5, 4'h0};
    vecs[5]  = '{2197, 0,    4'h0, 3'd5, 4'h0};
    vecs[6]  = '{2198, 0,    4'h0, 3'd6, 4'h0};
    vecs[7]  = '{2199, 0,    4'h0, 3'd6, 4'h0};
    vecs[8]  = '{2190, 1078, 4'h0, 3'd5, 4'h0};
    vecs[9]  = '{2199, 1078, 4'h0, 3'd6, 4'h0};
    vecs[10] = '{1920, 1079, 4'h0, 3'd0, 4'h0};
    vecs[11] = '{1919, 1079, 4'h0, 3'd7, 4'h0};
    vecs[12] = '{2190, 1079, 4'h0, 3'd0, 4'h0};
    vecs[13] = '{2199, 1079, 4'h0, 3'd0, 4'h0};
    vecs[14] = '{100,  1080, 4'h0, 3'd0, 4'h0};
    vecs[15] = '{2190, 1124, 4'h0, 3'd5, 4'h0};
    vecs[16] = '{2199, 1124, 4'h0, 3'd6, 4'h0};
    vecs[17] = '{0,    1124, 4'h0, 3'd0, 4'h0};
    vecs[18] = '{2189, 1124, 4'h0, 3'd0, 4'h0};

    repeat (3) @(posedge pixel_clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;

    foreach (vecs[i]) begin
      x = 12'(vecs[i].vx); y = 11'(vecs[i].vy); req = vecs[i].vreq;
      @(posedge pixel_clk);
      #1;
      chk($sformatf("vec%0d_period", i), int'(period), int'(vecs[i].vper));
      chk($sformatf("vec%0d_gnt", i), int'(gnt), int'(vecs[i].vgnt));
    end

    // Single requester on an active row: budget-limited chain of 7 packets.
    req = 4'b0001;
    run(10, 1900, 2199);
    chk("s2_ctrl_1931", int'(rp[1931]), 0);
    chk("s2_pre_1932", int'(rp[1932]), 1);
    chk("s2_pre_1939", int'(rp[1939]), 1);
    chk("s2_gl_1940", int'(rp[1940]), 2);
    chk("s2_gl_1941", int'(rp[1941]), 2);
    chk("s2_gnt_1941", int'(rg[1941]), 0);
    chk("s2_data_1942", int'(rp[1942]), 3);
    chk("s2_gnt_1942", int'(rg[1942]), 1);
    chk("s2_first_1942", int'(rf[1942]), 1);
    chk("s2_idx_1942", int'(ri[1942]), 0);
    chk("s2_idx_1973", int'(ri[1973]), 31);
    chk("s2_first_1973", int'(rf[1973]), 0);
    chk("s2_first_1974", int'(rf[1974]), 1);
    chk("s2_idx_2165", int'(ri[2165]), 31);
    chk("s2_gt_2166", int'(rp[2166]), 4);
    chk("s2_gt_2167", int'(rp[2167]), 4);
    chk("s2_ctrl_2168", int'(rp[2168]), 0);
    chk("s2_gnt_2168", int'(rg[2168]), 0);
    chk("s2_vpre_2190", int'(rp[2190]), 5);
    chk("s2_packets", count_first(1900, 2199), 7);
    chk("s2_errs", count_first(0, 0) * 0 + int'(re[1942] | re[2166] | re[2190]), 0);

    // Pointer sits at 1: requesters 2 and 0 alternate, 18-packet islands.
    req = 4'b0101;
    run(1100, 0, 2199);
    chk("s3_ctrl_11", int'(rp[11]), 0);
    chk("s3_pre_12", int'(rp[12]), 1);
    chk("s3_gnt_22", int'(rg[22]), 4);
    chk("s3_first_22", int'(rf[22]), 1);
    chk("s3_gnt_54", int'(rg[54]), 1);
    chk("s3_first_54", int'(rf[54]), 1);
    chk("s3_gnt_86", int'(rg[86]), 4);
    chk("s3_gt_598", int'(rp[598]), 4);
    chk("s3_pre_612", int'(rp[612]), 1);
    chk("s3_packets", count_first(0, 2199), 65);

    // All four requesting: strict rotation, capped at MaxPackets per island.
    req = 4'b1111;
    run(1101, 0, 2199);
    chk("s4_pre_0", int'(rp[0]), 1);
    chk("s4_gnt_10", int'(rg[10]), 8);
    chk("s4_island1_packets", count_first(0, 599), 18);
    chk("s4_gt_586", int'(rp[586]), 4);
    chk("s4_ctrl_588", int'(rp[588]), 0);
    chk("s4_ctrl_599", int'(rp[599]), 0);
    chk("s4_pre_600", int'(rp[600]), 1);
    begin
      int bad = 0;
      logic [3:0] prev = 4'h0;
      for (int k = 0; k < 600; k++) begin
        if (rf[k]) begin
          if (prev != 4'h0 && rg[k] != {prev[2:0], prev[3]}) bad++;
          prev = rg[k];
        end
      end
      chk("s4_rr_order", bad, 0);
    end

    // Raster jump into active video mid-packet aborts the island.
    req = 4'b0001;
    run(5, 1900, 1950);
    chk("s5_data_1950", int'(rp[1950]), 3);
    chk("s5_gnt_1950", int'(rg[1950]), 1);
    chk("s5_err_1950", int'(re[1950]), 0);
    run(5, 0, 1);
    chk("s5_abort_period", int'(rp[0]), 7);
    chk("s5_abort_gnt", int'(rg[0]), 0);
    chk("s5_abort_err", int'(re[0]), 1);
    chk("s5_err_drop", int'(re[1]), 0);
    chk("s5_video_1", int'(rp[1]), 7);

    // Aborted winner 0 keeps its turn over requester 1.
    req = 4'b0011;
    run(1102, 0, 60);
    chk("s5_retry_pre_12", int'(rp[12]), 1);
    chk("s5_retry_gnt_22", int'(rg[22]), 1);
    chk("s5_retry_gnt_54", int'(rg[54]), 2);

    // Reset mid-packet, then a fresh MinCtrl run before the next island.
    rst = 1'b1;
    #1;
    chk_reset("rst_async");
    run(1102, 61, 65);
    chk_reset("rst_held");
    rst = 1'b0;
    run(1102, 100, 112);
    chk("s6_ctrl_100", int'(rp[100]), 0);
    chk("s6_gnt_100", int'(rg[100]), 0);
    chk("s6_ctrl_111", int'(rp[111]), 0);
    chk("s6_pre_112", int'(rp[112]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/h14tx_island_sched.md
Name: h14tx_island_sched

Overview:
- Per-pixel period sequencer and data-island arbiter for the HDMI 1.4 TX channel path.
- Consumes the timing generator's x/y raster position and decides each pixel's channel period: control, video preamble/guard, video, or data-island preamble/guard/packet.
- Arbitrates N packet sources (AVI/audio InfoFrame, ACR, audio sample) round-robin for 32-pixel packet slots inside horizontal blanking.
- Sits between the timing generator and the TMDS encoder mux; packet-body serialisation stays in the packet sources.

Parameters:
- NumReq, 4, number of packet requesters (1..8)
- BitWidth, 12, x counter width
- BitHeight, 11, y counter width
- HActive, 1920, active pixels per line
- HTotal, 2200, total pixels per line
- VActive, 1080, active lines
- VTotal, 1125, total lines
- MinCtrl, 12, minimum control pixels before any preamble
- MaxPackets, 18, maximum packets per island

Ports:
- pixel_clk  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- x  in  BitWidth  raster column, 0..HTotal-1
- y  in  BitHeight  raster row, 0..VTotal-1
- req  in  NumReq  packet request, level, one per source
- gnt  out  NumReq  one-hot grant, held for the whole 32-pixel packet
- pkt_first  out  1  first pixel of a granted packet
- pkt_idx  out  5  pixel index within packet, 0..31
- period  out  3  period_t encoding of the current pixel
- sched_err  out  1  one-cycle pulse on a forced island abort

Behaviour:
- Interface (already decided): one clock, pixel_clk; rst is asynchronous, active-high.
- All outputs are registered and describe the x/y sampled on the previous edge (latency 1).
- Reset values: period=CTRL, gnt=0, pkt_first=0, pkt_idx=0, sched_err=0, RR pointer=0, ctrl_cnt=0, pkt_cnt=0.
- Definitions:
  - active_row = y<VActive.
  - next_active = (y==VTotal-1 ? 0 : y+1) < VActive.
  - vid_rsv = next_active ? 10 : 0.
- States and period encodings: CTRL=0, ISL_PRE=1, ISL_GUARD_L=2, ISL_DATA=3, ISL_GUARD_T=4, VID_PRE=5, VID_GUARD=6, VIDEO=7.
- VIDEO: active_row && x<HActive.
- VID_PRE: x in [HTotal-10, HTotal-3] when next_active.
- VID_GUARD: x in [HTotal-2, HTotal-1] when next_active.
- Video periods take priority over every island state.
- ctrl_cnt:
  - Counts consecutive CTRL pixels, saturating at MinCtrl.
  - Clears on any non-CTRL pixel and at reset.
- Island open, evaluated in CTRL only. All of the following must hold:
  - ctrl_cnt>=MinCtrl
  - |req
  - x + 44 + MinCtrl + vid_rsv <= HTotal
  - not VIDEO
- Island sequence:
  - ISL_PRE for 8 pixels, then ISL_GUARD_L for 2 pixels, then ISL_DATA.
  - Arbitration occurs on the last ISL_GUARD_L pixel.
- Arbitration:
  - Round-robin starting at the RR pointer.
  - Winner's gnt rises with pkt_first=1 and pkt_idx=0.
  - Pointer moves to winner+1 mod NumReq.
- Packet slot:
  - gnt is held for 32 pixels; pkt_idx increments 0..31.
  - req changes during the slot are ignored.
- Continuation, decided at pkt_idx=31. Chain the next packet (no gap, pkt_first=1) only if all hold:
  - |req
  - pkt_cnt<MaxPackets
  - x_end + 34 + MinCtrl + vid_rsv <= HTotal
  - Otherwise go to ISL_GUARD_T for 2 pixels, then CTRL.
- An island never crosses the x wrap. Lines with no request produce only CTRL and video periods.
- Simultaneous requests: exactly one grant per slot. A sole requester may win consecutive slots.
- Abort: if the VIDEO or VID_PRE condition arises while in an island state (raster jump or mode change):
  - Force that video period and drop gnt.
  - Pulse sched_err for one cycle.
  - RR pointer is not advanced past the aborted winner.
- Reset mid-island: immediate return to reset values; no resume. The next island needs MinCtrl control pixels.

Optional Feature:
- Macro: H14TX_ISLAND_STATS_EN.
- Defined:
  - Adds outputs isl_count[15:0] and pkt_count[15:0].
  - Both are saturating counters of islands opened and packets granted, cleared by rst.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- h14tx_pkg:
  - period_t enum.
  - Constants: IslPreLen=8, GuardLen=2, PktLen=32, VidPreLen=8.
  - Parameters are taken from the existing timings_cfg_t fields.
- Sub-module h14tx_rr_arb (NumReq-wide combinational round-robin pick plus registered pointer), instantiated once.

Test Plan:
- Reset, 1080p raster, req=0 → lines show only CTRL/VID_PRE/VID_GUARD/VIDEO; VID_PRE at x=2190..2197, VID_GUARD at x=2198..2199 on rows 1124 and 0..1078; gnt stays 0.
- req=4'b0001 held from x=1900, row 10 → ISL_PRE from 1-cycle-delayed x=1932; gnt[0] for 32 pixels; island limited by budget, ends ≥12 CTRL before x=2190.
- req=4'b1111 constant, row 1100 (vblank, next row inactive) → gnts in order 0,1,2,3,0… back to back; at most 18 packets per island.
- req=4'b0101, RR pointer=1 → first gnt=4'b0100, next gnt=4'b0001.
- x jumped to 0 mid-ISL_DATA on an active row → period=VIDEO, gnt=0, sched_err one pulse.
- rst asserted mid-packet, released 5 cycles later → outputs at reset values; no ISL_PRE until 12 CTRL pixels have elapsed.
